// File: rtl/reg_bus_sequencer_if.sv
// Command, response and register-bank bus signals of the reg_bus_sequencer.
// Handshakes: a cmd or rsp transfer happens at a rising edge where valid && ready are both 1;
// the sender holds its payload and keeps valid high until that edge, and ready may depend on state only.
interface reg_bus_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [17:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic [17:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ceb;
  logic        bus_web;
  logic        bus_reb;
  logic        bus_oeb;
  logic        busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_len, rsp_ready, bus_rdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_last,
    output bus_addr, bus_wdata, bus_ceb, bus_web, bus_reb, bus_oeb, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_len, rsp_ready, bus_rdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_last,
    input  bus_addr, bus_wdata, bus_ceb, bus_web, bus_reb, bus_oeb, busy
  );
endinterface

// File: rtl/reg_bus_sequencer.sv
// Turns single-word write and incrementing read-burst commands into strobed
// register-bank bus cycles and returns read words on a backpressured response channel.
module reg_bus_sequencer #(
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  reg_bus_sequencer_if.master bus,
  output logic [1:0]          fsm_state
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR      = 2'd1;
  localparam logic [1:0] RD_ADDR = 2'd2;
  localparam logic [1:0] RD_RESP = 2'd3;

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  logic [1:0] state;
  logic [3:0] remaining;
  logic [2:0] wait_cnt;
  logic       accept;

  assign bus.cmd_ready = (state == IDLE);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign fsm_state     = state;

  // Strobes are registered alongside the state so they change on the same edge as the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      remaining     <= 4'd0;
      wait_cnt      <= 3'd0;
      bus.busy      <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= 32'd0;
      bus.rsp_last  <= 1'b0;
      bus.bus_addr  <= 18'd0;
      bus.bus_wdata <= 32'd0;
      bus.bus_ceb   <= 1'b1;
      bus.bus_web   <= 1'b1;
      bus.bus_reb   <= 1'b1;
      bus.bus_oeb   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus.bus_addr <= bus.cmd_addr;
            bus.busy     <= 1'b1;
            bus.bus_ceb  <= 1'b0;
            if (bus.cmd_write) begin
              bus.bus_wdata <= bus.cmd_wdata;
              bus.bus_web   <= 1'b0;
              state         <= WR;
            end else begin
              remaining   <= bus.cmd_len;
              wait_cnt    <= 3'd0;
              bus.bus_reb <= 1'b0;
              bus.bus_oeb <= 1'b0;
              state       <= RD_ADDR;
            end
          end
        end

        WR: begin
          bus.bus_ceb <= 1'b1;
          bus.bus_web <= 1'b1;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end

        RD_ADDR: begin
          // The bank's registered output is valid in the cycle where the counter reaches LAT.
          if (wait_cnt == LAT) begin
            bus.rsp_data  <= bus.bus_rdata;
            bus.rsp_valid <= 1'b1;
            bus.rsp_last  <= (remaining == 4'd0);
            bus.bus_ceb   <= 1'b1;
            bus.bus_reb   <= 1'b1;
            bus.bus_oeb   <= 1'b1;
            state         <= RD_RESP;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end

        RD_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            if (remaining == 4'd0) begin
              bus.busy <= 1'b0;
              state    <= IDLE;
            end else begin
              bus.bus_addr <= bus.bus_addr + 18'd1;
              remaining    <= remaining - 4'd1;
              wait_cnt     <= 3'd0;
              bus.bus_ceb  <= 1'b0;
              bus.bus_reb  <= 1'b0;
              bus.bus_oeb  <= 1'b0;
              state        <= RD_ADDR;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Bench for reg_bus_sequencer: directed timing checks plus randomized traffic
// scored against a word-level memory model of the register bank.
module tb_reg_bus_sequencer;

  logic       clk;
  logic       rst;
  logic [1:0] fsm_state;
  logic       ready_dir;
  logic       rand_ready;
  logic       rand_bit;
  logic       prev_reb;
  int         checks;
  int         errors;

  logic [32:0] exp_q[$];      // {last, data} per expected response word
  logic [17:0] exp_addr_q[$]; // expected read addresses in bus order
  logic [49:0] exp_wr_q[$];   // {addr, data} per expected write cycle
  logic [31:0] ref_mem[logic [17:0]];
  logic [31:0] bank_mem[logic [17:0]];

  reg_bus_sequencer_if bus ();

  reg_bus_sequencer #(.RD_LATENCY(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  logic [3:0] strb;
  assign strb = {bus.bus_ceb, bus.bus_web, bus.bus_reb, bus.bus_oeb};
  assign bus.rsp_ready = rand_ready ? rand_bit : ready_dir;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // register bank: unwritten locations read back their own address, registered output
  function automatic logic [31:0] bank_rd(input logic [17:0] a);
    return bank_mem.exists(a) ? bank_mem[a] : {14'h0, a};
  endfunction

  always @(posedge clk) begin
    bus.bus_rdata <= bank_rd(bus.bus_addr);
    if (!bus.bus_ceb && !bus.bus_web) bank_mem[bus.bus_addr] = bus.bus_wdata;
  end

  always @(negedge clk) rand_bit = ($urandom_range(0, 3) != 0);

  // reference model: what a command should produce, at transaction level
  function automatic logic [31:0] ref_rd(input logic [17:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : {14'h0, a};
  endfunction

  task automatic model_accept(input bit w, input logic [17:0] a, input logic [31:0] d,
                              input logic [3:0] len);
    logic [17:0] ai;
    if (w) begin
      ref_mem[a] = d;
      exp_wr_q.push_back({a, d});
    end else begin
      for (int i = 0; i <= int'(len); i++) begin
        ai = a + 18'(i);
        exp_q.push_back({(i == int'(len)), ref_rd(ai)});
        exp_addr_q.push_back(ai);
      end
    end
  endtask

  // scoreboard / bus monitor, sampled with pre-edge values
  always @(posedge clk) begin
    if (rst) begin
      prev_reb <= 1'b1;
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else chk("rsp_word", {bus.rsp_last, bus.rsp_data}, exp_q.pop_front());
      end
      if (!bus.bus_ceb && !bus.bus_web) begin
        chk("wr_strobes", strb, 4'b0011);
        if (exp_wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else chk("wr_cycle", {bus.bus_addr, bus.bus_wdata}, exp_wr_q.pop_front());
      end
      if (!bus.bus_ceb && !bus.bus_reb && prev_reb) begin
        chk("rd_strobes", strb, 4'b0100);
        if (exp_addr_q.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_addr", bus.bus_addr, exp_addr_q.pop_front());
      end
      prev_reb <= bus.bus_reb;
    end
  end

  // driver: called at a negedge, returns at the negedge after acceptance
  task automatic send_cmd(input bit w, input logic [17:0] a, input logic [31:0] d,
                          input logic [3:0] len);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_len   = len;
    while (!bus.cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("cmd_accept_timeout", 0, 1);
    @(posedge clk);
    model_accept(w, a, d, len);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input bit expect_blocked);
    int n = 0;
    while (!bus.rsp_valid && n < 20) begin
      if (expect_blocked) chk({tag, "_cmd_ready"}, bus.cmd_ready, 0);
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    bit seen;
    int n;
    logic [17:0] a;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    ready_dir     = 1'b1;
    rand_ready    = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_len   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset values
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_last, bus.rsp_data}, 0);
    chk("rst_bus", {bus.bus_addr, bus.bus_wdata}, 0);
    chk("rst_strobes", strb, 4'hF);

    // write then back-to-back write
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1;
    bus.cmd_addr = 18'h00010; bus.cmd_wdata = 32'h12345678; bus.cmd_len = 4'd0;
    @(posedge clk); model_accept(1, 18'h00010, 32'h12345678, 0);
    @(negedge clk);
    chk("wr1_strobes", strb, 4'b0011);
    chk("wr1_bus", {bus.bus_addr, bus.bus_wdata}, {18'h00010, 32'h12345678});
    chk("wr1_rsp_valid", bus.rsp_valid, 0);
    chk("wr1_cmd_ready", bus.cmd_ready, 0);
    bus.cmd_addr = 18'h00011; bus.cmd_wdata = 32'h9ABCDEF0;
    @(negedge clk);
    chk("wr_gap_cmd_ready", bus.cmd_ready, 1);
    chk("wr_gap_strobes", strb, 4'hF);
    @(posedge clk); model_accept(1, 18'h00011, 32'h9ABCDEF0, 0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("wr2_strobes", strb, 4'b0011);
    chk("wr2_bus", {bus.bus_addr, bus.bus_wdata}, {18'h00011, 32'h9ABCDEF0});
    @(negedge clk);

    // single read, RD_LATENCY=1
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 18'h00020; bus.cmd_len = 4'd0;
    @(posedge clk); model_accept(0, 18'h00020, 0, 0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("rd1_c0", {strb, bus.bus_addr, bus.rsp_valid}, {4'b0100, 18'h00020, 1'b0});
    @(negedge clk);
    chk("rd1_c1", {strb, bus.rsp_valid}, {4'b0100, 1'b0});
    @(negedge clk);
    chk("rd1_rsp", {bus.rsp_valid, bus.rsp_last, bus.rsp_data}, {2'b11, 32'h00000020});
    chk("rd1_rsp_strobes", {strb, bus.busy}, {4'hF, 1'b1});
    @(negedge clk);
    chk("rd1_after", {bus.rsp_valid, bus.cmd_ready, bus.busy}, 3'b010);

    // wrapping burst with a stall on word 2 and a command held throughout
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 18'h3FFFE; bus.cmd_len = 4'd3;
    @(posedge clk); model_accept(0, 18'h3FFFE, 0, 3);
    @(negedge clk);
    bus.cmd_write = 1'b1; bus.cmd_addr = 18'h00055; bus.cmd_wdata = 32'hA5A5A5A5;
    for (int w = 0; w < 4; w++) begin
      wait_valid("burst", 1);
      chk("burst_cmd_ready_v", bus.cmd_ready, 0);
      if (w == 1) begin
        ready_dir = 1'b0;
        repeat (5) begin
          chk("stall_word2", {bus.rsp_valid, bus.rsp_data}, {1'b1, 32'h0003FFFF});
          chk("stall_strobes", strb, 4'hF);
          @(negedge clk);
        end
        ready_dir = 1'b1;
      end
      @(negedge clk);
    end
    chk("burst_end_ready", {bus.cmd_ready, bus.busy}, 2'b10);
    @(posedge clk); model_accept(1, 18'h00055, 32'hA5A5A5A5, 0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("held_wr", {strb, bus.bus_addr}, {4'b0011, 18'h00055});
    @(negedge clk);

    // reset during RD_RESP of word 2 of 4
    send_cmd(0, 18'h00100, 0, 4'd3);
    wait_valid("rstb_w1", 0);
    @(negedge clk);
    wait_valid("rstb_w2", 0);
    ready_dir = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rsp", {bus.rsp_valid, bus.rsp_last, bus.rsp_data}, 0);
    chk("async_rst_bus", {strb, bus.bus_addr, bus.bus_wdata}, {4'hF, 50'd0});
    chk("async_rst_ctl", {bus.cmd_ready, bus.busy}, 2'b10);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    ready_dir = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_after_rst", seen, 0);
    send_cmd(1, 18'h00200, 32'hCAFEF00D, 0);
    chk("post_rst_wr", {strb, bus.bus_addr, bus.bus_wdata}, {4'b0011, 18'h00200, 32'hCAFEF00D});
    @(negedge clk);
    chk("post_rst_idle", {strb, bus.cmd_ready}, {4'hF, 1'b1});

    // randomized traffic with random response backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: a = 18'h3FFF0 + 18'($urandom_range(0, 15));
        1: a = 18'($urandom_range(0, 31));
        2: a = 18'h00100 + 18'($urandom_range(0, 15));
        default: a = 18'($urandom);
      endcase
      send_cmd(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    n = 0;
    while ((bus.busy || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", (n >= 2000), 0);
    rand_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("exp_addr_q_empty", exp_addr_q.size(), 0);
    chk("exp_wr_q_empty", exp_wr_q.size(), 0);
    chk("final_idle", {bus.cmd_ready, bus.busy, bus.rsp_valid, strb}, {3'b100, 4'hF});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
